// File: rtl/gwas_div_pkg.sv
// Shared types and sizing helpers for the iterative fixed-point divider.
// GWAS_DIV_ROUND_EN adds one guard iteration for round-half-up quotients.
package gwas_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef GWAS_DIV_ROUND_EN
  localparam int GUARD_BITS = 1;
`else
  localparam int GUARD_BITS = 0;
`endif

  // Counter width; never returns 0 so a one-iteration divider still has a bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  function automatic int calc_q_w(input int data_width, input int frac_bits);
    return data_width + frac_bits;
  endfunction

  function automatic int calc_iter(input int data_width, input int frac_bits);
    return calc_q_w(data_width, frac_bits) + GUARD_BITS;
  endfunction

endpackage

// File: rtl/gwas_div_step.sv
// One combinational radix-2 restoring step: shift a dividend bit into the
// partial remainder and subtract the divisor when it fits.
module gwas_div_step #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_rem,
  input  logic                  i_bit,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic                  o_qbit
);

  logic [DATA_WIDTH:0]   w_rem_t;
  logic [DATA_WIDTH-1:0] w_diff;

  assign w_rem_t = {i_rem, i_bit};
  // When the subtraction is taken the result is below the divisor, so the
  // low DATA_WIDTH bits of the difference are exact.
  assign w_diff  = w_rem_t[DATA_WIDTH-1:0] - i_divisor;
  assign o_qbit  = (w_rem_t >= {1'b0, i_divisor});
  assign o_rem   = o_qbit ? w_diff : w_rem_t[DATA_WIDTH-1:0];

endmodule

// File: rtl/gwas_iter_divider.sv
// Iterative unsigned fixed-point divider: quotient = floor(a * 2^FRAC_BITS / b).
// Define GWAS_DIV_ROUND_EN for round-half-up quotients via one guard bit.
module gwas_iter_divider
  import gwas_div_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 16,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_dividend,
  input  logic [DATA_WIDTH-1:0]           in_divisor,
  input  logic [TAG_WIDTH-1:0]            in_tag,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH+FRAC_BITS-1:0] out_quotient,
  output logic [DATA_WIDTH-1:0]           out_remainder,
  output logic                            out_dbz,
  output logic [TAG_WIDTH-1:0]            out_tag,
  output logic                            busy
);

  localparam int Q_W   = calc_q_w(DATA_WIDTH, FRAC_BITS);
  localparam int ITER  = calc_iter(DATA_WIDTH, FRAC_BITS);
  localparam int CNT_W = clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  state_t                r_state;
  state_t                w_next_state;

  logic [Q_W-1:0]        r_shift;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_divisor;
  logic [ITER-1:0]       r_quot;
  logic [CNT_W-1:0]      r_cnt;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic                  r_dbz;

  logic                  r_out_valid;
  logic [Q_W-1:0]        r_out_quotient;
  logic [DATA_WIDTH-1:0] r_out_remainder;
  logic                  r_out_dbz;
  logic [TAG_WIDTH-1:0]  r_out_tag;

  logic                  w_accept;
  logic                  w_div_zero;
  logic                  w_last;
  logic                  w_finalize;
  logic                  w_handshake;
  logic [DATA_WIDTH-1:0] w_step_rem;
  logic                  w_qbit;
  logic [Q_W-1:0]        w_quot_final;
  logic [DATA_WIDTH-1:0] w_rem_final;

  assign w_accept    = in_valid && in_ready;
  assign w_div_zero  = (in_divisor == '0);
  assign w_last      = (r_cnt == LAST_CNT);
  // The first DONE cycle formats the result; out_valid rises on the next edge.
  assign w_finalize  = (r_state == DONE) && !r_out_valid;
  assign w_handshake = r_out_valid && out_ready;

  gwas_div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_shift[Q_W-1]),
    .i_divisor(r_divisor),
    .o_rem    (w_step_rem),
    .o_qbit   (w_qbit)
  );

  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: each always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = w_div_zero ? DONE : CALC;
      CALC:    if (w_last) w_next_state = DONE;
      DONE:    if (w_handshake) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
    endcase
  end

`ifdef GWAS_DIV_ROUND_EN
  logic [DATA_WIDTH-1:0] r_rem_qw;
  logic [Q_W:0]          w_round_sum;

  assign w_round_sum = {1'b0, r_quot[ITER-1:1]} + {{Q_W{1'b0}}, r_quot[0]};
`endif

  // NOTE: datapath registers are not reset; every one is loaded on accept
  // before it is read, and the FSM alone decides validity.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift   <= Q_W'(in_dividend) << FRAC_BITS;
      r_rem     <= w_div_zero ? in_dividend : '0;
      r_cnt     <= '0;
      r_divisor <= in_divisor;
      r_tag     <= in_tag;
      r_dbz     <= w_div_zero;
    end else if (r_state == CALC) begin
      r_shift <= {r_shift[Q_W-2:0], 1'b0};
      r_rem   <= w_step_rem;
      r_quot  <= {r_quot[ITER-2:0], w_qbit};
      r_cnt   <= r_cnt + 1'b1;
`ifdef GWAS_DIV_ROUND_EN
      // Keep the remainder that belongs to the unrounded Q_W-bit quotient.
      if (r_cnt == CNT_W'(Q_W - 1)) r_rem_qw <= w_step_rem;
`endif
    end
  end

  always_comb begin
    w_quot_final = '1;
    w_rem_final  = r_rem;
    if (!r_dbz) begin
`ifdef GWAS_DIV_ROUND_EN
      w_quot_final = w_round_sum[Q_W] ? '1 : w_round_sum[Q_W-1:0];
      w_rem_final  = r_rem_qw;
`else
      w_quot_final = r_quot;
      w_rem_final  = r_rem;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid     <= 1'b0;
      r_out_quotient  <= '0;
      r_out_remainder <= '0;
      r_out_dbz       <= 1'b0;
      r_out_tag       <= '0;
    end else if (w_finalize) begin
      r_out_valid     <= 1'b1;
      r_out_quotient  <= w_quot_final;
      r_out_remainder <= w_rem_final;
      r_out_dbz       <= r_dbz;
      r_out_tag       <= r_tag;
    end else if (w_handshake) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_quotient  = r_out_quotient;
  assign out_remainder = r_out_remainder;
  assign out_dbz       = r_out_dbz;
  assign out_tag       = r_out_tag;

endmodule

// File: tb/tb_gwas_iter_divider.sv
// Scoreboard bench for gwas_iter_divider (DATA_WIDTH=16, FRAC_BITS=16).
// Expectations follow GWAS_DIV_ROUND_EN when it is defined.
module tb_gwas_iter_divider;

  localparam int DW  = 16;
  localparam int FB  = 16;
  localparam int TW  = 4;
  localparam int QW  = DW + FB;
`ifdef GWAS_DIV_ROUND_EN
  localparam int LAT = QW + 2;
`else
  localparam int LAT = QW + 1;
`endif

  typedef struct {
    logic [QW-1:0] q;
    logic [DW-1:0] r;
    logic [TW-1:0] tag;
    logic          dbz;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dividend;
  logic [DW-1:0] in_divisor;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_quotient;
  logic [DW-1:0] out_remainder;
  logic          out_dbz;
  logic [TW-1:0] out_tag;
  logic          busy;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  gwas_iter_divider #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FB),
    .TAG_WIDTH (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
    .out_remainder(out_remainder),
    .out_dbz      (out_dbz),
    .out_tag      (out_tag),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: plain integer divide, no bit-serial modelling.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [TW-1:0] t);
    exp_t e;
    longint unsigned num;
    longint unsigned q;
    e.tag = t;
    if (b == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      num   = longint'(a) << FB;
      e.r   = DW'(num % b);
      e.dbz = 1'b0;
      e.lat = LAT;
`ifdef GWAS_DIV_ROUND_EN
      q = ((num << 1) / b);
      q = (q >> 1) + (q & 64'd1);
      if (q > 64'hFFFF_FFFF) q = 64'hFFFF_FFFF;
`else
      q = num / b;
`endif
      e.q = QW'(q);
    end
    return e;
  endfunction

  // Drive one operation, wait for its result, compare against the scoreboard,
  // then either retire it immediately (early_ready) or after `hold` stalled cycles.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TW-1:0] t, input bit early_ready, input int hold);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = t;
    out_ready   = early_ready;
    sb.push_back(model(a, b, t));
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_dividend = DW'($urandom);
    in_divisor  = DW'($urandom);
    in_tag      = TW'($urandom);
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check("result_seen", got, 1);
    if (!got || sb.size() == 0) return;
    e = sb.pop_front();
    check("latency", n, e.lat);
    check("quotient", out_quotient, e.q);
    check("remainder", out_remainder, e.r);
    check("tag", out_tag, e.tag);
    check("dbz", out_dbz, e.dbz);
    check("busy_done", busy, 1);
    check("in_ready_done", in_ready, 0);
    if (!early_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_quotient", out_quotient, e.q);
        check("hold_remainder", out_remainder, e.r);
        check("hold_in_ready", in_ready, 0);
        // An in_valid pulse while busy must be ignored.
        if (i == 3) begin
          in_valid    = 1'b1;
          in_dividend = 16'd1;
          in_divisor  = 16'd1;
        end else begin
          in_valid = 1'b0;
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("retire_valid", out_valid, 0);
    check("retire_in_ready", in_ready, 1);
    check("retire_busy", busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    in_tag      = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quotient", out_quotient, 0);
    check("rst_remainder", out_remainder, 0);
    check("rst_dbz", out_dbz, 0);
    check("rst_tag", out_tag, 0);
    rst = 1'b0;

    run_op(16'd1, 16'd3, 4'd5, 1'b1, 0);
    run_op(16'd7, 16'd2, 4'd1, 1'b1, 0);
    run_op(16'hFFFF, 16'd1, 4'd2, 1'b1, 0);
    run_op(16'd5, 16'd0, 4'd3, 1'b1, 0);
    run_op(16'd2, 16'd3, 4'd4, 1'b0, 10);
    run_op(16'd0, 16'd0, 4'd6, 1'b0, 2);
    run_op(16'hFFFF, 16'hFFFF, 4'd7, 1'b1, 0);

    // Reset while CALC is at iteration 12 must discard the operation.
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = 16'd100;
    in_divisor  = 16'd7;
    in_tag      = 4'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_quotient", out_quotient, 0);
    check("mid_rst_remainder", out_remainder, 0);
    check("mid_rst_tag", out_tag, 0);
    seen = 1'b0;
    for (int i = 0; i < QW + 5; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", seen, 0);
    run_op(16'd9, 16'd3, 4'd8, 1'b1, 0);

    for (int i = 0; i < 8; i++) begin
      run_op(DW'($urandom), DW'($urandom_range(1, (i < 4) ? 20 : 65535)),
             TW'($urandom), (i % 2) == 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gwas_iter_divider.md
Name: gwas_iter_divider

Overview:
Parametrised iterative unsigned fixed-point divider for the boost calculation path. It returns quotient = floor(dividend * 2^FRAC_BITS / divisor) and the matching remainder. It uses a radix-2 restoring algorithm, one quotient bit per cycle, with no vendor float IP. Operands enter and results leave through valid/ready handshakes, and a caller tag passes through with the result. Divide-by-zero is flagged instead of being left undefined.

Parameters:
DATA_WIDTH, 16, width of dividend, divisor and remainder
FRAC_BITS, 16, number of fractional quotient bits; quotient width Q_W = DATA_WIDTH + FRAC_BITS
TAG_WIDTH, 4, width of the pass-through tag

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_dividend  input  DATA_WIDTH  unsigned dividend
in_divisor  input  DATA_WIDTH  unsigned divisor
in_tag  input  TAG_WIDTH  caller tag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_quotient  output  Q_W  fixed-point quotient, FRAC_BITS fractional bits
out_remainder  output  DATA_WIDTH  final partial remainder, always < divisor
out_dbz  output  1  divisor was zero
out_tag  output  TAG_WIDTH  tag captured at accept
busy  output  1  state is not IDLE

Behaviour:
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - out_quotient, out_remainder, out_dbz and out_tag are all 0.
- Reset applies mid-calculation: an in-flight operation is discarded and no result is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - Accept occurs when in_valid && in_ready. On accept, latch divisor and tag.
  - Load the shift register with {in_dividend, FRAC_BITS'b0}. Clear the partial remainder and the iteration counter.
  - If divisor == 0: go to DONE, with quotient = all ones, remainder = in_dividend and dbz = 1.
  - Otherwise go to CALC.
- CALC, each cycle:
  - rem_t = {rem, msb of shift register}, which is DATA_WIDTH+1 bits.
  - If rem_t >= divisor: rem = rem_t - divisor and qbit = 1. Otherwise rem = rem_t[DATA_WIDTH-1:0] and qbit = 0.
  - Shift qbit into the quotient LSB.
  - The counter runs 0..ITER-1, with ITER = Q_W. On the last iteration go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - Outputs are held stable until out_ready.
  - On out_valid && out_ready go to IDLE.
  - The next accept happens no earlier than the cycle after the handshake; there is no same-cycle turnaround.
- Latency:
  - Normal: accept at edge k, out_valid first high after edge k+ITER+1.
  - Divide-by-zero: out_valid high after edge k+1.
- in_valid is ignored while not in IDLE. Operand inputs do not need to be held after accept.
- out_ready held high while entering DONE still costs one cycle of out_valid (a minimum one-cycle pulse).
- Width rules:
  - Quotient overflow is impossible: Q_W bits cover the dividend maximum at divisor 1.
  - Remainder fits DATA_WIDTH because rem < divisor.

Optional Feature:
GWAS_DIV_ROUND_EN
- Defined:
  - ITER = Q_W + 1; one guard bit is computed.
  - out_quotient = (raw >> 1) + guard, i.e. round-half-up. If the sum would exceed the all-ones value, saturate to all ones.
  - out_remainder reports the unrounded remainder of the Q_W-bit result.
  - Normal latency becomes ITER+1 = Q_W+2.
  - Divide-by-zero output is unchanged.
- Undefined: truncation, ITER = Q_W.

Decomposition:
- Package gwas_div_pkg:
  - state enum {IDLE, CALC, DONE};
  - function clog2 for counter width;
  - localparam helpers Q_W and ITER derived from the parameters.
- Sub-module gwas_div_step: combinational single restoring step. Inputs rem, in_bit, divisor; outputs new rem, qbit. It is instantiated once and used iteratively.

Test Plan (DATA_WIDTH=16, FRAC_BITS=16):
- 1/3, tag 5 -> quotient 0x00005555, remainder 1, tag 5, dbz 0; out_valid exactly 33 cycles after accept.
- 7/2 -> quotient 0x00038000, remainder 0. 0xFFFF/1 -> quotient 0xFFFF0000, remainder 0.
- 5/0 -> out_valid 1 cycle after accept; quotient 0xFFFFFFFF, remainder 5, dbz 1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, and an in_valid pulse is ignored. Then out_ready=1 -> back to IDLE next cycle.
- Reset asserted at CALC iteration 12 -> next cycle IDLE, out_valid=0, all outputs 0. A following 9/3 gives 0x00030000.
- With GWAS_DIV_ROUND_EN:
  - 2/3 -> 0x0000AAAB; 1/3 -> 0x00005555.
  - Latency 34 cycles.
  - 0xFFFF/1 -> 0xFFFF0000, no saturation.
